vid_timing_gen: RTL and testbench

- Frame sequencer for the pixel-clock video datapath.
- Counts pixels and lines to produce `vid_vsync`, `vid_hsync`, `vid_de` and `vid_data` for the DVI/TMDS encoder input stage.
- Pulls pixels from an upstream source, or from an internal colour-bar generator when compiled in.
- Starts and stops only on frame boundaries, so downstream never sees a truncated frame.

---
 rtl/vid_pkg.sv | 24 ++
 rtl/vid_bar_gen.sv | 37 +++
 rtl/vid_timing_gen.sv | 151 +++++++++++++++
 tb/tb_vid_timing_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// Shared types and constants for the video timing generator.
package vid_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int NUM_BARS = 8;

    // Index 0 is the leftmost bar on screen.
    localparam logic [0:NUM_BARS-1][23:0] BAR_COLOURS = {
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/vid_bar_gen.sv
// Eight-bar colour pattern source, stepped one pixel per active cycle.
module vid_bar_gen
    import vid_pkg::*;
#(
    parameter int BAR_W = 80
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_active,
    output rgb_t o_colour
);

    localparam int            IW          = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [IW-1:0] IN_BAR_LAST = IW'(BAR_W - 1);

    logic [IW-1:0] r_in_bar;
    logic [2:0]    r_bar;

    // Both counters rest at zero through blanking, so every line begins on bar 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_in_bar <= '0;
            r_bar    <= '0;
        end else if (!i_active) begin
            r_in_bar <= '0;
            r_bar    <= '0;
        end else if (r_in_bar == IN_BAR_LAST) begin
            r_in_bar <= '0;
            r_bar    <= r_bar + 3'd1;
        end else begin
            r_in_bar <= r_in_bar + IW'(1);
        end
    end

    assign o_colour = rgb_t'(BAR_COLOURS[r_bar]);

endmodule

// File: rtl/vid_timing_gen.sv
// Pixel/line sequencer producing sync, DE and pixel data for the TMDS encoder.
// Define VID_TIMING_GEN_PATTERN_EN to replace pix_data with internal colour bars.
module vid_timing_gen
    import vid_pkg::*;
#(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0
) (
    input  logic        PixelClk,
    input  logic        aRst_n,
    input  logic        enable,
    output logic        pix_req,
    input  logic [23:0] pix_data,
    output logic        vid_vsync,
    output logic        vid_hsync,
    output logic        vid_de,
    output logic [23:0] vid_data,
    output logic        frame_start,
    output logic        busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    if (H_ACTIVE % 8 != 0) begin : g_bad_h_active
        $error("vid_timing_gen: H_ACTIVE must be a multiple of 8");
    end

    state_t        r_state;
    state_t        w_state_nxt;
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_running;
    logic          w_active;
    logic          w_hs_region;
    logic          w_vs_region;
    rgb_t          w_pixel;

    logic          r_vid_vsync;
    logic          r_vid_hsync;
    logic          r_vid_de;
    logic [23:0]   r_vid_data;
    logic          r_frame_start;
    logic          r_busy;

    assign w_h_last    = (r_h_cnt == H_LAST);
    assign w_v_last    = (r_v_cnt == V_LAST);
    assign w_running   = (r_state != ST_IDLE);
    assign w_active    = (int'(r_h_cnt) < H_ACTIVE) && (int'(r_v_cnt) < V_ACTIVE);
    assign w_hs_region = (int'(r_h_cnt) >= H_ACTIVE + H_FP) &&
                         (int'(r_h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
    assign w_vs_region = (int'(r_v_cnt) >= V_ACTIVE + V_FP) &&
                         (int'(r_v_cnt) <  V_ACTIVE + V_FP + V_SYNC);
    assign pix_req     = w_running && w_active;

`ifdef VID_TIMING_GEN_PATTERN_EN
    logic w_unused_pix;
    assign w_unused_pix = ^pix_data;

    vid_bar_gen #(
        .BAR_W    (H_ACTIVE / 8)
    ) u_bar_gen (
        .i_clk    (PixelClk),
        .i_rst_n  (aRst_n),
        .i_active (pix_req),
        .o_colour (w_pixel)
    );
`else
    assign w_pixel = rgb_t'(pix_data);
`endif

    // A stopping request only takes effect on the last pixel, so frames are never cut short.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (enable) w_state_nxt = ST_RUN;
            ST_RUN:   if (!enable) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (enable)
                    w_state_nxt = ST_RUN;
                else if (w_h_last && w_v_last)
                    w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge PixelClk or negedge aRst_n) begin
        if (!aRst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge PixelClk or negedge aRst_n) begin
        if (!aRst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!w_running) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
        end
    end

    // Outputs trail the counters by one cycle; blanking forces data to zero.
    always_ff @(posedge PixelClk or negedge aRst_n) begin
        if (!aRst_n) begin
            r_vid_de      <= 1'b0;
            r_vid_data    <= '0;
            r_vid_hsync   <= ~H_POL;
            r_vid_vsync   <= ~V_POL;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_vid_de      <= pix_req;
            r_vid_data    <= pix_req ? w_pixel : '0;
            r_vid_hsync   <= (w_running && w_hs_region) ? H_POL : ~H_POL;
            r_vid_vsync   <= (w_running && w_vs_region) ? V_POL : ~V_POL;
            r_frame_start <= pix_req && (r_h_cnt == '0) && (r_v_cnt == '0);
            r_busy        <= (w_state_nxt != ST_IDLE);
        end
    end

    assign vid_de      = r_vid_de;
    assign vid_data    = r_vid_data;
    assign vid_hsync   = r_vid_hsync;
    assign vid_vsync   = r_vid_vsync;
    assign frame_start = r_frame_start;
    assign busy        = r_busy;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Directed bench for vid_timing_gen with small timing (H 8/2/2/2, V 4/1/1/1, positive syncs).
// A frame-position model pushes expected outputs to a scoreboard each cycle.
module tb_vid_timing_gen;

    localparam int HT = 14;
    localparam int FT = 98;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic        busy;
        logic [23:0] data;
    } expT;

    logic        PixelClk = 1'b0;
    logic        aRst_n   = 1'b1;
    logic        enable   = 1'b0;
    logic [23:0] pix_data = '0;
    logic        pix_req;
    logic        vid_vsync;
    logic        vid_hsync;
    logic        vid_de;
    logic [23:0] vid_data;
    logic        frame_start;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int          mState = 0;
    int          mPos   = 0;
    logic [23:0] pixCount = 24'h000100;
    expT         expQ[$];
    logic [23:0] pixQ[$];

    int cycle, deCount, busyCount, fsCount, firstFs, lastFs, fsGap;

    logic [23:0] barTable [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    always #5 PixelClk = ~PixelClk;

    vid_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .H_POL    (1'b1), .V_POL (1'b1)
    ) dut (
        .PixelClk    (PixelClk),
        .aRst_n      (aRst_n),
        .enable      (enable),
        .pix_req     (pix_req),
        .pix_data    (pix_data),
        .vid_vsync   (vid_vsync),
        .vid_hsync   (vid_hsync),
        .vid_de      (vid_de),
        .vid_data    (vid_data),
        .frame_start (frame_start),
        .busy        (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearStats();
        cycle     = 0;
        deCount   = 0;
        busyCount = 0;
        fsCount   = 0;
        firstFs   = -1;
        lastFs    = -1;
        fsGap     = -1;
    endtask

    function automatic logic [23:0] expPixel(input logic [23:0] src, input int h);
`ifdef VID_TIMING_GEN_PATTERN_EN
        return barTable[h];
`else
        return (h >= 0) ? src : 24'h0;
`endif
    endfunction

    task automatic checkRegistered();
        expT e;
        checkOutput("scoreboard_entry", expQ.size() > 0, 1'b1);
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("vid_de",      vid_de,      e.de);
            checkOutput("vid_data",    vid_data,    e.data);
            checkOutput("vid_hsync",   vid_hsync,   e.hs);
            checkOutput("vid_vsync",   vid_vsync,   e.vs);
            checkOutput("frame_start", frame_start, e.fs);
            checkOutput("busy",        busy,        e.busy);
        end
        cycle++;
        if (busy === 1'b1) busyCount++;
        if (vid_de === 1'b1) begin
            deCount++;
            checkOutput("pixel_pending", pixQ.size() > 0, 1'b1);
            if (pixQ.size() > 0) checkOutput("pixel_order", vid_data, pixQ.pop_front());
        end
        if (frame_start === 1'b1) begin
            fsCount++;
            if (firstFs < 0) firstFs = cycle;
            if (lastFs >= 0) fsGap = cycle - lastFs;
            lastFs = cycle;
        end
    endtask

    task automatic applyStimulus(input logic en);
        expT  e;
        int   h, v, nState, nPos;
        logic running, act;
        logic [23:0] pixVal;
        @(negedge PixelClk);
        enable  = en;
        h       = mPos % HT;
        v       = mPos / HT;
        running = (mState != 0) && aRst_n;
        act     = running && (h < 8) && (v < 4);
        if (act) begin
            pixVal   = pixCount;
            pixCount = pixCount + 24'd1;
        end else begin
            pixVal = 24'($urandom);
        end
        pix_data = pixVal;
        #1;
        checkOutput("pix_req", pix_req, act);
        if (!aRst_n)          nState = 0;
        else if (mState == 0) nState = en ? 1 : 0;
        else if (mState == 1) nState = en ? 1 : 2;
        else                  nState = en ? 1 : ((mPos == FT - 1) ? 0 : 2);
        nPos   = running ? (mPos + 1) % FT : 0;
        e.de   = act;
        e.data = act ? expPixel(pixVal, h) : 24'h0;
        e.hs   = running && (h == 10 || h == 11);
        e.vs   = running && (v == 5);
        e.fs   = act && (mPos == 0);
        e.busy = (nState != 0);
        expQ.push_back(e);
        if (act) pixQ.push_back(e.data);
        @(posedge PixelClk);
        #1;
        mState = nState;
        mPos   = nPos;
        checkRegistered();
    endtask

    task automatic checkIdleNow(input string tag);
        checkOutput({tag, "_de"},    vid_de,      1'b0);
        checkOutput({tag, "_data"},  vid_data,    24'h0);
        checkOutput({tag, "_hsync"}, vid_hsync,   1'b0);
        checkOutput({tag, "_vsync"}, vid_vsync,   1'b0);
        checkOutput({tag, "_fs"},    frame_start, 1'b0);
        checkOutput({tag, "_busy"},  busy,        1'b0);
        checkOutput({tag, "_req"},   pix_req,     1'b0);
    endtask

    initial begin
        clearStats();

        $display("[TB] reset values");
        #1 aRst_n = 1'b0;
        #1 checkIdleNow("reset");
        repeat (2) @(posedge PixelClk);
        @(negedge PixelClk);
        aRst_n = 1'b1;

        $display("[TB] idle with enable low");
        for (int i = 0; i < 50; i++) applyStimulus(1'b0);
        checkOutput("idle_de_count",   deCount,   0);
        checkOutput("idle_busy_count", busyCount, 0);

        $display("[TB] continuous run, three frames");
        clearStats();
        for (int i = 0; i < 3 * FT; i++) applyStimulus(1'b1);
        checkOutput("run_de_count",    deCount, 96);
        checkOutput("run_fs_count",    fsCount, 3);
        checkOutput("run_first_fs",    firstFs, 2);
        checkOutput("run_fs_interval", fsGap,   FT);

        $display("[TB] enable dropped in line 2, frame drains");
        clearStats();
        for (int i = 0; i < 31; i++)  applyStimulus(1'b1);
        for (int i = 0; i < 100; i++) applyStimulus(1'b0);
        checkOutput("drain_busy_count", busyCount, FT);
        checkOutput("drain_de_count",   deCount,   32);
        checkOutput("drain_fs_count",   fsCount,   1);

        $display("[TB] enable dropped and re-raised within a frame");
        clearStats();
        for (int i = 0; i < 41; i++)  applyStimulus(1'b1);
        for (int i = 0; i < 20; i++)  applyStimulus(1'b0);
        for (int i = 0; i < 100; i++) applyStimulus(1'b1);
        checkOutput("rerun_fs_count",    fsCount, 2);
        checkOutput("rerun_fs_interval", fsGap,   FT);
        checkOutput("rerun_busy_count",  busyCount, 161);

        $display("[TB] reset pulsed in the back porch");
        for (int i = 0; i < 20 && (mPos % HT) != 12; i++) applyStimulus(1'b1);
        checkOutput("bp_hsync_before_reset", vid_hsync, 1'b1);
        @(negedge PixelClk);
        aRst_n = 1'b0;
        #1 checkIdleNow("midframe_reset");
        mState = 0;
        mPos   = 0;
        for (int i = 0; i < 2; i++) applyStimulus(1'b1);
        aRst_n = 1'b1;
        clearStats();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1);
        checkOutput("restart_fs_cycle", firstFs, 2);
        checkOutput("scoreboard_drained", pixQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
